// File: rtl/sub4_serial.sv
// Bit-serial subtractor: D = A - B - BI, one bit per clock, LSB first, registered borrow.
// Optional signed-overflow output ovf when SUB4_SERIAL_OVF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on accept
// SHIFT   | one difference bit per edge, WIDTH edges total
// DONE    | single-cycle done pulse, d/bo/ovf already loaded
module sub4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SUB4_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Only WIDTH-1 bits are kept; the last bit goes straight into d on the final shift.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             x;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] res_next;

`ifdef SUB4_SERIAL_OVF_EN
  logic amsb_q, amsb_d;
  logic bmsb_q, bmsb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    d_d      = d_q;
    br_d     = br_q;
    bo_d     = bo_q;
    cnt_d    = cnt_q;
`ifdef SUB4_SERIAL_OVF_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    x        = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next  = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);
    last     = (cnt_q == CW'(WIDTH - 1));
    res_next = {x, res_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bi;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SUB4_SERIAL_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_next[WIDTH-1:1];
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          d_d     = res_next;
          bo_d    = br_next;
`ifdef SUB4_SERIAL_OVF_EN
          ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ x);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SUB4_SERIAL_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
`ifdef SUB4_SERIAL_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign d    = d_q;
  assign bo   = bo_q;
`ifdef SUB4_SERIAL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
